// File: rtl/job_request_assembler.sv
// job_request_assembler
//   Collects NWORDS host words from an AXI-Stream slave into one JOB_W-bit
//   job request and presents it on an AXI-Stream master output register.
//   Frames with the wrong length are dropped and counted in err_count.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/   host word stream (tlast marks the end of frame)
//   tready/tlast
//   m_axis_tdata/tvalid/   assembled job request
//   tready
//   job_count              jobs emitted (wraps)
//   err_count              malformed frames dropped (saturates at 255)
//   busy                   low only when idle: COLLECT, idx 0, output empty
//
// state   | meaning
// COLLECT | accepting words of a frame into the assembly register
// HOLD    | complete job waiting for the output register to free up
// DISCARD | overlong frame, swallowing words up to and including tlast
module job_request_assembler #(
  parameter int WORD_W = 32,
  parameter int JOB_W  = 576
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [WORD_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [JOB_W-1:0]  m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [15:0]       job_count,
  output logic [7:0]        err_count,
  output logic              busy
);

  localparam int NWORDS = JOB_W / WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {COLLECT, HOLD, DISCARD} state_t;

  state_t             state;
  state_t             next_state;
  logic [IDX_W-1:0]   idx;
  logic [JOB_W-1:0]   asm_q;
  logic [JOB_W-1:0]   asm_next;
  logic [JOB_W-1:0]   load_data;
  logic               accept;
  logic               emit;
  logic               out_free;
  logic               at_last;
  logic               load_job;

  always_comb begin
    accept   = s_axis_tvalid && s_axis_tready;
    emit     = m_axis_tvalid && m_axis_tready;
    // Output register can take a new job if empty or being drained this cycle.
    out_free = !m_axis_tvalid || m_axis_tready;
    at_last  = (idx == LAST_IDX);

    asm_next = asm_q;
    for (int k = 0; k < NWORDS; k++) begin
      if (idx == IDX_W'(k)) asm_next[k*WORD_W +: WORD_W] = s_axis_tdata;
    end

    next_state = state;
    load_job   = 1'b0;
    case (state)
      COLLECT: begin
        if (accept && at_last) begin
          if (!s_axis_tlast)  next_state = DISCARD;
          else if (out_free)  load_job = 1'b1;
          else                next_state = HOLD;
        end
      end
      HOLD: begin
        if (out_free) begin
          load_job   = 1'b1;
          next_state = COLLECT;
        end
      end
      DISCARD: begin
        if (accept && s_axis_tlast) next_state = COLLECT;
      end
      default: next_state = COLLECT;
    endcase

    // In HOLD the final word is already stored in asm_q.
    load_data = (state == HOLD) ? asm_q : asm_next;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= COLLECT;
      idx           <= '0;
      asm_q         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      s_axis_tready <= 1'b0;
      job_count     <= '0;
      err_count     <= '0;
    end else begin
      state         <= next_state;
      // Registered from next state only, never from m_axis_tready.
      s_axis_tready <= (next_state != HOLD);

      if (state == COLLECT && accept) begin
        asm_q <= asm_next;
        if (at_last || s_axis_tlast) idx <= '0;
        else                         idx <= idx + 1'b1;
        // Early tlast (short) or missing tlast on the last word (long).
        if ((at_last != s_axis_tlast) && (err_count != 8'hFF))
          err_count <= err_count + 8'd1;
      end

      if (load_job) begin
        m_axis_tdata  <= load_data;
        m_axis_tvalid <= 1'b1;
      end else if (emit) begin
        m_axis_tvalid <= 1'b0;
      end

      if (emit) job_count <= job_count + 16'd1;
    end
  end

  assign busy = !((state == COLLECT) && (idx == '0) && !m_axis_tvalid);

endmodule

// File: tb/tb_job_request_assembler.sv
module tb_job_request_assembler;

  localparam int WORD_W = 32;
  localparam int JOB_W  = 576;
  localparam int NWORDS = 18;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [WORD_W-1:0] s_tdata = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic              s_tlast = 1'b0;
  logic [JOB_W-1:0]  m_tdata;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic [15:0]       job_count;
  logic [7:0]        err_count;
  logic              busy;

  job_request_assembler #(.WORD_W(WORD_W), .JOB_W(JOB_W)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .job_count     (job_count),
    .err_count     (err_count),
    .busy          (busy)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  logic [JOB_W-1:0] exp_q[$];
  int exp_jobs = 0;
  int exp_err  = 0;
  int stall_cnt = 0;
  logic [JOB_W-1:0] held_data;
  bit held = 0;
  bit f3_done = 0;

  typedef struct {
    int len;
    bit with_last;
    bit exp_emit;
    bit exp_err_inc;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [JOB_W-1:0] act,
                       input logic [JOB_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Output monitor / scoreboard: sampled on the falling edge, the handshake
  // seen here completes at the following rising edge.
  always @(negedge aclk) begin
    if (!aresetn) begin
      held = 0;
    end else begin
      if (s_tvalid && !s_tready) stall_cnt++;
      if (m_tvalid && held) check("hold_stable", m_tdata, held_data);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_job got=%0h expected=none", m_tdata);
        end else begin
          check("job_data", m_tdata, exp_q.pop_front());
        end
        exp_jobs = (exp_jobs + 1) & 16'hFFFF;
        held = 0;
      end else if (m_tvalid) begin
        held = 1;
        held_data = m_tdata;
      end else begin
        held = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the last word is accepted.
  task automatic send_frame(input int len, input bit with_last, input bit good,
                            input bit bad, input bit force_w,
                            input logic [31:0] w0, input logic [31:0] w16);
    logic [WORD_W-1:0] words[$];
    logic [JOB_W-1:0]  job;
    logic [WORD_W-1:0] w;
    int n;
    job = '0;
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      if (force_w && i == 0)  w = w0;
      if (force_w && i == 16) w = w16;
      words.push_back(w);
      if (i < NWORDS) job[i*WORD_W +: WORD_W] = w;
    end
    if (good) exp_q.push_back(job);
    for (int i = 0; i < len; i++) begin
      s_tdata  = words[i];
      s_tvalid = 1'b1;
      s_tlast  = with_last && (i == len - 1);
      n = 0;
      @(negedge aclk);
      while (!s_tready && n < 200) begin
        @(negedge aclk);
        n++;
      end
      if (n >= 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got=tready_low expected=tready_high word=%0d", i);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        return;
      end
      @(posedge aclk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (bad && exp_err < 255) exp_err++;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 500) begin
      @(posedge aclk);
      #1;
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout got=pending expected=empty", tag);
    end
    @(posedge aclk);
    #1;
    check({tag, "_job_count"}, JOB_W'(job_count), JOB_W'(exp_jobs));
    check({tag, "_err_count"}, JOB_W'(err_count), JOB_W'(exp_err));
    check({tag, "_busy_idle"}, JOB_W'(busy), JOB_W'(0));
    check({tag, "_tready_idle"}, JOB_W'(s_tready), JOB_W'(1));
  endtask

  task automatic do_reset(input string tag);
    aresetn = 1'b0;
    #1;
    exp_q.delete();
    exp_jobs = 0;
    exp_err  = 0;
    check({tag, "_rst_tvalid"}, JOB_W'(m_tvalid), JOB_W'(0));
    check({tag, "_rst_tdata"}, m_tdata, '0);
    check({tag, "_rst_job_count"}, JOB_W'(job_count), JOB_W'(0));
    check({tag, "_rst_err_count"}, JOB_W'(err_count), JOB_W'(0));
    check({tag, "_rst_busy"}, JOB_W'(busy), JOB_W'(0));
    check({tag, "_rst_tready"}, JOB_W'(s_tready), JOB_W'(0));
    @(posedge aclk);
    #1;
    check({tag, "_rst_tready_held"}, JOB_W'(s_tready), JOB_W'(0));
    aresetn = 1'b1;
    #1;
    check({tag, "_tready_before_edge"}, JOB_W'(s_tready), JOB_W'(0));
    @(posedge aclk);
    #1;
    check({tag, "_tready_after_edge"}, JOB_W'(s_tready), JOB_W'(1));
  endtask

  initial begin
    int s0;
    vecs[0] = '{18, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{6,  1'b1, 1'b0, 1'b1};
    vecs[2] = '{18, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{20, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1,  1'b1, 1'b0, 1'b1};
    vecs[5] = '{17, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{19, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{18, 1'b1, 1'b1, 1'b0};

    @(posedge aclk);
    #1;
    do_reset("init");

    // Directed first frame with known word 0 and job_ID word.
    send_frame(18, 1'b1, 1'b1, 1'b0, 1'b1, 32'h05F5E100, 32'hFFFFFF01);
    check("first_tvalid", JOB_W'(m_tvalid), JOB_W'(1));
    check("first_word0", JOB_W'(m_tdata[31:0]), JOB_W'(32'h05F5E100));
    check("first_job_id", JOB_W'(m_tdata[519:512]), JOB_W'(8'h01));
    drain("first");
    check("first_job_count_one", JOB_W'(job_count), JOB_W'(1));

    // Table of good, short and long frames.
    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].len, vecs[v].with_last, vecs[v].exp_emit,
                 vecs[v].exp_err_inc, 1'b0, '0, '0);
      drain($sformatf("vec%0d", v));
    end

    // Full-rate back-to-back frames must not stall the host.
    s0 = stall_cnt;
    for (int f = 0; f < 3; f++) send_frame(18, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    check("b2b_no_stall", JOB_W'(stall_cnt - s0), JOB_W'(0));
    drain("b2b");

    // Backpressure: frame 1 parks in the output, frame 2 in HOLD, frame 3 waits.
    m_tready = 1'b0;
    send_frame(18, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    send_frame(18, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    f3_done = 0;
    fork
      begin
        send_frame(18, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        f3_done = 1;
      end
    join_none
    repeat (4) begin
      @(posedge aclk);
      #1;
    end
    check("hold_tready_low", JOB_W'(s_tready), JOB_W'(0));
    check("hold_busy", JOB_W'(busy), JOB_W'(1));
    check("hold_tvalid", JOB_W'(m_tvalid), JOB_W'(1));
    check("hold_no_emit", JOB_W'(job_count), JOB_W'(exp_jobs));
    m_tready = 1'b1;
    for (int n = 0; n < 300 && !f3_done; n++) begin
      @(posedge aclk);
      #1;
    end
    check("hold_f3_sent", JOB_W'(f3_done), JOB_W'(1));
    drain("hold");

    // Reset in the middle of a frame drops the partial job.
    send_frame(10, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    do_reset("mid");
    send_frame(18, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    drain("after_rst");
    check("after_rst_job_count_one", JOB_W'(job_count), JOB_W'(1));

    // Error counter saturation.
    for (int f = 0; f < 300; f++) send_frame(2, 1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
    drain("sat");
    check("sat_err_255", JOB_W'(err_count), JOB_W'(8'hFF));
    send_frame(18, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    drain("sat_then_good");

    check("scoreboard_empty", JOB_W'(exp_q.size()), JOB_W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL global_timeout got=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/job_request_assembler.md
JOB_REQUEST_ASSEMBLER -- requirements
Module: job_request_assembler

Interface
REQ-001 Parameter WORD_W, default 32, SHALL set the input stream word width in bits.
REQ-002 Parameter JOB_W, default 576, SHALL set the job request width in bits; JOB_W SHALL be an integer multiple of WORD_W, and NWORDS = JOB_W/WORD_W (18 at defaults).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  WORD_W  host word
- s_axis_tvalid  in  1  host word valid
- s_axis_tready  out  1  block accepts word
- s_axis_tlast  in  1  last word of frame
- m_axis_tdata  out  JOB_W  assembled job request
- m_axis_tvalid  out  1  job valid
- m_axis_tready  in  1  downstream CCRF wrapper ready
- job_count  out  16  jobs emitted, wrapping
- err_count  out  8  malformed frames dropped, saturating at 255
- busy  out  1  high unless state is COLLECT with word index 0 and m_axis_tvalid low

Function
REQ-005 A beat SHALL be accepted when s_axis_tvalid and s_axis_tready are both high on a rising aclk edge; a job SHALL be emitted when m_axis_tvalid and m_axis_tready are both high.
REQ-006 Accepted word k (0..NWORDS-1) of a frame SHALL be written to assembly bits [WORD_W*k+WORD_W-1 : WORD_W*k]; word 0 is least significant, so job_ID bits [519:512] are word 16 bits [7:0].
REQ-007 The state machine SHALL have the states COLLECT, HOLD and DISCARD, with a word index idx of ceil(log2(NWORDS)) bits.
REQ-008 COLLECT: s_axis_tready = 1; each accepted beat increments idx.
REQ-009 COLLECT, accepted beat with idx < NWORDS-1 and tlast = 1 (short frame): the partial job SHALL be dropped, idx set to 0, err_count incremented, and the state SHALL remain COLLECT.
REQ-010 COLLECT, accepted beat with idx = NWORDS-1 and tlast = 0 (long frame): the job SHALL be dropped, err_count incremented, idx set to 0, next state DISCARD.
REQ-011 COLLECT, accepted beat with idx = NWORDS-1 and tlast = 1: if the output register is empty, or is emitting in that same cycle, the job SHALL load into the output register and m_axis_tvalid SHALL be high on the next cycle (1-cycle latency); otherwise next state SHALL be HOLD.
REQ-012 HOLD: s_axis_tready = 0; the job SHALL load into the output register in the first cycle the register is empty or emitting, then the state SHALL return to COLLECT with idx = 0.
REQ-013 DISCARD: s_axis_tready = 1; beats SHALL be accepted and ignored until a beat with tlast = 1 is accepted, then the state SHALL return to COLLECT.
REQ-014 The output register SHALL hold m_axis_tdata stable while m_axis_tvalid is high and m_axis_tready is low; m_axis_tvalid SHALL clear after an emission unless a new job loads in the same cycle.
REQ-015 job_count SHALL increment by 1 on each emission and wrap 0xFFFF -> 0x0000.
REQ-016 err_count SHALL saturate at 0xFF.
REQ-017 s_axis_tready SHALL be a registered function of state only and SHALL NOT depend combinationally on m_axis_tready.
REQ-018 Back-to-back frames SHALL be sustained at one word per cycle whenever downstream accepts each job within NWORDS cycles.

Reset
REQ-019 When aresetn is low, the state SHALL be COLLECT, idx = 0, m_axis_tvalid = 0, m_axis_tdata = 0, job_count = 0, err_count = 0 and busy = 0; s_axis_tready SHALL be 0 while aresetn is low and 1 from the first edge after release.
REQ-020 Reset asserted mid-frame or in HOLD SHALL discard all partial and pending jobs without emitting them.

Verification
REQ-021 18 words with m_axis_tready = 1: word0 = 0x05F5E100, word16 = 0xFFFFFF01, tlast on word 17 -> one cycle after word 17, m_axis_tvalid = 1, tdata[31:0] = 0x05F5E100, tdata[519:512] = 0x01; then job_count = 1.
REQ-022 tlast on word 5 -> no emission, err_count = 1; the next 18-word frame emits normally.
REQ-023 20-word frame with tlast only on word 19 -> no emission, err_count = 1, state COLLECT after word 19; the following good frame emits.
REQ-024 m_axis_tready = 0 and three good frames sent -> frame 1 held stable in the output register, frame 2 in HOLD, s_axis_tready = 0; on raising m_axis_tready, frames 1 and 2 emit in order, then frame 3 is accepted.
REQ-025 aresetn pulsed low after word 9 -> all outputs at reset values; the next full frame emits with job_count = 1.
REQ-026 300 short frames -> err_count = 255 (saturated).
